// File: rtl/sin_angle_reducer_if.sv
// Handshake bundle between the angle source, the angle reducer and the Sin core.
// The cos_sel line exists only when SIN_COS_MODE_EN is defined.
interface sin_angle_reducer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_deg;
`ifdef SIN_COS_MODE_EN
    logic         cos_sel;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_deg;
    logic [1:0]   out_quad;
    logic         out_neg;

    modport master (
        output in_valid,
        input  in_ready,
        output in_deg,
`ifdef SIN_COS_MODE_EN
        output cos_sel,
`endif
        input  out_valid,
        output out_ready,
        input  out_deg,
        input  out_quad,
        input  out_neg
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_deg,
`ifdef SIN_COS_MODE_EN
        input  cos_sel,
`endif
        output out_valid,
        input  out_ready,
        output out_deg,
        output out_quad,
        output out_neg
    );
endinterface

// File: rtl/sin_angle_reducer.sv
// Reduces a raw degree angle modulo FULL_DEG and folds it into the first quadrant for the Sin core.
// Optional feature macro: SIN_COS_MODE_EN (adds cos_sel, shifting the angle by a quarter turn).
module sin_angle_reducer #(
    parameter int W        = 16,
    parameter int FULL_DEG = 360,
    parameter int STEPS    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sin_angle_reducer_if.slave bus
);
    localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [W:0] FULL_W1 = (W+1)'(FULL_DEG);
    localparam logic [W:0] QTR_W1  = (W+1)'(FULL_DEG / 4);
    localparam logic [W:0] HALF_W1 = (W+1)'(FULL_DEG / 2);
    localparam logic [W:0] TQTR_W1 = (W+1)'((3 * FULL_DEG) / 4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_MAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [W-1:0] deg;
        logic [1:0]   quad;
        logic         neg;
    } fold_t;

    // Folds a reduced angle (0..FULL_DEG-1) into quadrant-one magnitude, quadrant and sign.
    function automatic fold_t fold_angle(input logic [W-1:0] rem, input logic cos);
        logic [W:0] r;
        fold_t      f;
        r = {1'b0, rem} + (cos ? QTR_W1 : (W+1)'(0));
        if (r >= FULL_W1) begin
            r = r - FULL_W1;
        end else begin
            r = r;
        end
        if (r < QTR_W1) begin
            f.deg  = W'(r);
            f.quad = 2'd0;
            f.neg  = 1'b0;
        end else if (r < HALF_W1) begin
            f.deg  = W'(HALF_W1 - r);
            f.quad = 2'd1;
            f.neg  = 1'b0;
        end else if (r < TQTR_W1) begin
            f.deg  = W'(r - HALF_W1);
            f.quad = 2'd2;
            f.neg  = 1'b1;
        end else begin
            f.deg  = W'(FULL_W1 - r);
            f.quad = 2'd3;
            f.neg  = 1'b1;
        end
        return f;
    endfunction

    state_t         state_r;
    logic [W-1:0]   rem_r;
    logic [KW-1:0]  k_r;
    logic           cos_r;
    logic           out_valid_r;
    logic [W-1:0]   out_deg_r;
    logic [1:0]     out_quad_r;
    logic           out_neg_r;

    logic [W:0]     shifted_s;
    logic [W-1:0]   rem_step_s;
    fold_t          fold_s;

    // One restoring step against FULL_DEG<<k (kept at W+1 bits so it never wraps), plus the fold.
    always_comb begin
        shifted_s  = FULL_W1 << k_r;
        rem_step_s = rem_r;
        if ({1'b0, rem_r} >= shifted_s) begin
            rem_step_s = W'({1'b0, rem_r} - shifted_s);
        end else begin
            rem_step_s = rem_r;
        end
        fold_s = fold_angle(rem_r, cos_r);
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rem_r       <= {W{1'b0}};
            k_r         <= {KW{1'b0}};
            cos_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_deg_r   <= {W{1'b0}};
            out_quad_r  <= 2'd0;
            out_neg_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        rem_r   <= bus.in_deg;
                        k_r     <= KW'(STEPS - 1);
`ifdef SIN_COS_MODE_EN
                        cos_r   <= bus.cos_sel;
`else
                        cos_r   <= 1'b0;
`endif
                        state_r <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    rem_r <= rem_step_s;
                    if (k_r == {KW{1'b0}}) begin
                        state_r <= ST_MAP;
                    end else begin
                        k_r <= k_r - KW'(1);
                    end
                end
                ST_MAP: begin
                    out_deg_r   <= fold_s.deg;
                    out_quad_r  <= fold_s.quad;
                    out_neg_r   <= fold_s.neg;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_deg   = out_deg_r;
    assign bus.out_quad  = out_quad_r;
    assign bus.out_neg   = out_neg_r;
endmodule

// File: tb/tb_sin_angle_reducer.sv
// Self-checking bench for sin_angle_reducer: directed table, corner sequences and a random sweep.
// Cos-mode vectors are applied only when SIN_COS_MODE_EN is defined.
module tb_sin_angle_reducer;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    sin_angle_reducer_if #(.W(W)) bif ();

    sin_angle_reducer #(.W(W), .FULL_DEG(360), .STEPS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned in_deg;
        bit          cos;
        int unsigned exp_deg;
        int unsigned exp_quad;
        int unsigned exp_neg;
    } vec_t;

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain modulo arithmetic followed by the quadrant rule table.
    task automatic ref_fold(input int unsigned deg, input bit cos,
                            output int unsigned d, output int unsigned q, output int unsigned n);
        int unsigned r;
        r = (deg + (cos ? 90 : 0)) % 360;
        if (r < 90)       begin d = r;       q = 0; n = 0; end
        else if (r < 180) begin d = 180 - r; q = 1; n = 0; end
        else if (r < 270) begin d = r - 180; q = 2; n = 1; end
        else              begin d = 360 - r; q = 3; n = 1; end
    endtask

    task automatic drive_cos(input bit cos);
`ifdef SIN_COS_MODE_EN
        bif.cos_sel = cos;
`else
        if (cos) $display("note: cos requested in sin-only build");
`endif
    endtask

    // Full transaction: accept, measure latency, check result, optionally stall, then handshake.
    task automatic do_txn(input int unsigned deg, input bit cos, input int unsigned ed,
                          input int unsigned eq, input int unsigned en, input int hold);
        int waited;
        int edges;
        string tag;
        tag = $sformatf("deg%0d_cos%0d", deg, cos);
        waited = 0;
        @(negedge clk);
        while (!bif.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_in_ready"}, bif.in_ready, 1);
        bif.in_valid = 1'b1;
        bif.in_deg   = W'(deg);
        drive_cos(cos);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.in_deg   = W'($urandom);
        drive_cos(1'b0);
        while (!bif.out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_latency"}, edges, 10);
        check({tag, "_deg"},  bif.out_deg,  ed);
        check({tag, "_quad"}, bif.out_quad, eq);
        check({tag, "_neg"},  bif.out_neg,  en);
        for (int i = 0; i < hold; i++) begin
            bif.in_valid = 1'b1;
            bif.in_deg   = W'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"}, bif.out_valid, 1);
            check({tag, "_hold_ready"}, bif.in_ready, 0);
            check({tag, "_hold_deg"},   bif.out_deg, ed);
            check({tag, "_hold_quad"},  bif.out_quad, eq);
            check({tag, "_hold_neg"},   bif.out_neg, en);
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.out_ready = 1'b0;
        check({tag, "_valid_drop"}, bif.out_valid, 0);
        check({tag, "_ready_back"}, bif.in_ready, 1);
    endtask

    initial begin
        vec_t        tbl[$];
        int unsigned d, q, n, deg;
        bit          cos;
        int          seen_valid;

        vectors     = 0;
        miscompares = 0;
        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_deg    = '0;
        bif.out_ready = 1'b0;
        drive_cos(1'b0);

        tbl.push_back('{30,    1'b0, 30, 0, 0});
        tbl.push_back('{150,   1'b0, 30, 1, 0});
        tbl.push_back('{210,   1'b0, 30, 2, 1});
        tbl.push_back('{330,   1'b0, 30, 3, 1});
        tbl.push_back('{0,     1'b0, 0,  0, 0});
        tbl.push_back('{90,    1'b0, 90, 1, 0});
        tbl.push_back('{180,   1'b0, 0,  2, 1});
        tbl.push_back('{270,   1'b0, 90, 3, 1});
        tbl.push_back('{360,   1'b0, 0,  0, 0});
        tbl.push_back('{359,   1'b0, 1,  3, 1});
        tbl.push_back('{65535, 1'b0, 15, 0, 0});
`ifdef SIN_COS_MODE_EN
        tbl.push_back('{0,     1'b1, 90, 1, 0});
        tbl.push_back('{300,   1'b1, 30, 0, 0});
        tbl.push_back('{180,   1'b1, 90, 3, 1});
        tbl.push_back('{65535, 1'b1, 75, 1, 0});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_out_deg",   bif.out_deg, 0);
        check("rst_out_quad",  bif.out_quad, 0);
        check("rst_out_neg",   bif.out_neg, 0);
        check("rst_in_ready",  bif.in_ready, 1);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            do_txn(tbl[i].in_deg, tbl[i].cos, tbl[i].exp_deg, tbl[i].exp_quad, tbl[i].exp_neg, 0);
        end

        // Downstream stall with in_valid asserted and in_deg changing
        do_txn(150, 1'b0, 30, 1, 0, 5);
        do_txn(210, 1'b0, 30, 2, 1, 0);

        // Reset pulse while reducing
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_deg   = W'(200);
        @(negedge clk);
        bif.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bif.out_valid, 0);
        check("midrst_in_ready",  bif.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (bif.out_valid) seen_valid++;
        end
        check("midrst_no_output", seen_valid, 0);
        do_txn(45, 1'b0, 45, 0, 0, 0);

        // Random sweep against the reference model
        for (int i = 0; i < 40; i++) begin
            deg = $urandom_range(0, 65535);
`ifdef SIN_COS_MODE_EN
            cos = 1'($urandom_range(0, 1));
`else
            cos = 1'b0;
`endif
            ref_fold(deg, cos, d, q, n);
            do_txn(deg, cos, d, q, n, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
